// File: rtl/wishbone_pkg.sv
// Shared types for the Wishbone classic single-transfer controller.
//   wb_status_t     : completion status reported on rsp_status_o
//   wb_ctrl_state_t : controller FSM state encoding
package wishbone_pkg;

  typedef enum logic [1:0] {
    WB_OK      = 2'd0,
    WB_ERR     = 2'd1,
    WB_RTY     = 2'd2,
    WB_TIMEOUT = 2'd3
  } wb_status_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } wb_ctrl_state_t;

endpackage

// File: rtl/wishbone_classic_timeout.sv
// Response wait counter for the Wishbone classic controller.
// Only instantiated when WB_CTRL_TIMEOUT_EN is defined.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clr_i     : clear the count (held while the request phase is inactive)
//   en_i      : count one request cycle that saw no response
//   expired_o : this is the TIMEOUT_CYCLES-th request cycle without response
module wishbone_classic_timeout
  import wishbone_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of silent request cycles already seen, so the
  // current silent cycle is the last one allowed when it equals LastCnt.
  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/wishbone_classic_ctrl.sv
// Wishbone classic single-transfer master controller.
// Accepts one command at a time, runs it on the bus, retries on rty_i up to
// MAX_RETRY times (one idle cycle between attempts) and reports a one-cycle
// completion pulse with status and read data.
// Optional feature: define WB_CTRL_TIMEOUT_EN to abort a request that gets no
// response within TIMEOUT_CYCLES request cycles (status TIMEOUT).
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    : command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i : command fields
//   rsp_valid_o, rsp_dat_o, rsp_status_o      : completion (wb_status_t)
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o : bus request
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i    : bus response
module wishbone_classic_ctrl
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i
);

  localparam int RtyW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RtyW-1:0] MaxRetry = RtyW'(MAX_RETRY);

  wb_ctrl_state_t state_q, state_d;
  wb_status_t     rsp_status_q, rsp_status_d;

  logic [RtyW-1:0]       retry_q, retry_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0]  sel_q;

  logic accept;
  logic any_rsp;
  logic timeout_hit;

  assign accept  = cmd_valid_i && (state_q == ST_IDLE);
  assign any_rsp = wb_ack_i || wb_err_i || wb_rty_i;

`ifdef WB_CTRL_TIMEOUT_EN
  // Counter is held clear outside REQ, so every entry into REQ (first
  // attempt or after a backoff) starts a fresh wait window.
  wishbone_classic_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != ST_REQ),
    .en_i      ((state_q == ST_REQ) && !any_rsp),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_REQ;
          retry_d = '0;
        end
      end
      ST_REQ: begin
        // err wins over ack, ack wins over rty
        if (wb_err_i) begin
          rsp_status_d = WB_ERR;
          rsp_dat_d    = '0;
          state_d      = ST_RESP;
        end else if (wb_ack_i) begin
          rsp_status_d = WB_OK;
          rsp_dat_d    = we_q ? '0 : wb_dat_i;
          state_d      = ST_RESP;
        end else if (wb_rty_i) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + RtyW'(1);
            state_d = ST_BACKOFF;
          end else begin
            rsp_status_d = WB_RTY;
            rsp_dat_d    = '0;
            state_d      = ST_RESP;
          end
        end else if (timeout_hit) begin
          rsp_status_d = WB_TIMEOUT;
          rsp_dat_d    = '0;
          state_d      = ST_RESP;
        end
      end
      ST_BACKOFF: state_d = ST_REQ;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      retry_q      <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WB_OK;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      if (accept) begin
        we_q  <= cmd_we_i;
        adr_q <= cmd_adr_i;
        dat_q <= cmd_dat_i;
        sel_q <= cmd_sel_i;
      end
    end
  end

  // Handshake and strobes are forced low while reset is asserted so that an
  // aborted transfer drops off the bus and no stale pulse escapes.
  assign cmd_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign wb_cyc_o     = (state_q == ST_REQ) && !rst_i;
  assign wb_stb_o     = (state_q == ST_REQ) && !rst_i;
  assign rsp_valid_o  = (state_q == ST_RESP) && !rst_i;

  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;

endmodule
